vga_rx_monitor: RTL
===================

# vga_rx_monitor

Receive-side counterpart of the VGA timing generator: samples hsync/vsync/red/green/blue as driven to the connector, recovers pixel coordinates, and checks 640x480@60 timing. Used in simulation loopback and on-board self-test to confirm the generated picture. Outputs are a locked flag, captured active pixels with coordinates, a frame-start pulse, and a saturating error counter.

## Interface

- CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel)
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in pixels (H_TOTAL = sum = 800)
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines (V_TOTAL = 525)
- LOCK_FRAMES, 2, consecutive clean frames required to lock
- clk  input  1  system clock, the 50 MHz board clock
- rst_n  input  1  asynchronous, active-low reset
- hsync  input  1  horizontal sync, active low
- vsync  input  1  vertical sync, active low
- red, green, blue  input  1 each  pixel colour
- locked  output  1  timing verified
- pix_valid  output  1  one-clk strobe per active pixel (only while locked)
- pix_x  output  10  active column 0..639
- pix_y  output  10  active row 0..479
- pix_rgb  output  3  {red, green, blue} of that pixel
- frame_start  output  1  one-clk pulse at each line-count reset
- err_count  output  8  timing errors, saturates at 255

## Operation

- Input stage: hsync, vsync, rgb registered once; sync falling edge = previous registered 1, current 0.
- Pixel tick: div counter 0..CLK_DIV-1; forced to 0 on hsync fall; tick when div==0 (hsync fall cycle is a tick).
- h_cnt: set to 0 on hsync fall, else +1 per tick, saturates at 2*H_TOTAL-1.
- On hsync fall: line length L = old h_cnt+1; L != H_TOTAL -> line error (except first line after reset/SEARCH).
- Timeout: h_cnt reaching 2*H_TOTAL-1 -> one line error, no further until next hsync fall.
- vsync fall sets vs_pend; next hsync fall: v_cnt <= 0, vs_pend cleared, frame_start pulses, frame length F = old v_cnt+1 checked vs V_TOTAL (frame error if unequal, skipped for first frame). Otherwise hsync fall increments v_cnt (saturates at 1023).
- Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144,783], v_cnt in [V_SYNC+V_BP, +V_ACTIVE-1] = [35,514]. pix_x = h_cnt-144, pix_y = v_cnt-35 (10-bit).
- pix_valid = tick AND active AND locked.
- Lock FSM (clean = no line/frame error since previous frame_start):
  - SEARCH: locked=0; clean-counter cleared; first frame_start -> MEASURE.
  - MEASURE: at each frame_start: clean -> count+1, reaching LOCK_FRAMES -> LOCKED; not clean -> count 0, stay.
  - LOCKED: locked=1; any line/frame error -> SEARCH same cycle the error is detected.
- err_count: +1 per line or frame error (both same cycle -> +1 only), holds at 255; cleared only by reset.

## Timing

- Reset (async assert, any time incl. mid-frame): locked=0, pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_start=0, err_count=0, FSM=SEARCH, h_cnt=v_cnt=div=0, vs_pend=0, input regs=1 (sync idle high), rgb regs 0. First-line/first-frame checks skipped after release.
- Latency: input pin sample -> registered output 2 clks (input reg + output reg). pix_rgb/pix_x/pix_y registered together with pix_valid; held between strobes.
- locked rises the cycle after the LOCK_FRAMES-th clean frame_start; falls 1 clk after the offending hsync fall/timeout is registered.
- frame_start and pix_valid never assert in the same cycle (h_cnt=0 is outside active range).
- pix_valid strobes spaced CLK_DIV clks; 640 per line, 307200 per frame.

## Test plan

- Ideal generator loopback, 3 frames -> locked rises after 2nd clean frame_start; err_count=0; 3rd frame gives 307200 pix_valid, first (0,0), last (639,479).
- Single green pixel at generator x=300, y=200 -> exactly one pix_valid with pix_rgb=3'b010 at pix_x=300, pix_y=200 per frame.
- One line lengthened to 801 pixels while locked -> locked drops, err_count=1, relocks after 2 further clean frames.
- hsync held high 1700 pixels -> one error (timeout), locked=0, err_count +1 only once until hsync resumes.
- Frame with 524 lines -> frame error, err_count +1, FSM to SEARCH; 300 corrupted lines continuously -> err_count saturates at 255.
- rst_n pulsed low mid-frame while locked -> all outputs zero immediately; no error counted for the partial first line/frame; relock after 2 clean frames.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates from hsync/vsync/rgb, checks
// line and frame timing, and captures active pixels once the timing is locked.
module vga_rx_monitor #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       red,
    input  logic       green,
    input  logic       blue,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       frame_start,
    output logic [7:0] err_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_MAX   = 2 * H_TOTAL - 1;
    localparam int unsigned HW      = $clog2(2 * H_TOTAL);
    localparam int unsigned VW      = 10;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CW      = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE - 1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [2:0]    rgb_q, rgb_d;
    logic          hs_prev_q, hs_prev_d;
    logic          vs_prev_q, vs_prev_d;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          vs_pend_q, vs_pend_d;
    logic          skip_line_q, skip_line_d;
    logic          skip_frame_q, skip_frame_d;
    logic          clean_q, clean_d;
    logic [CW-1:0] clean_cnt_q, clean_cnt_d;
    state_e        state_q, state_d;
    logic          locked_q, locked_d;
    logic          pix_valid_q, pix_valid_d;
    logic [9:0]    pix_x_q, pix_x_d;
    logic [9:0]    pix_y_q, pix_y_d;
    logic [2:0]    pix_rgb_q, pix_rgb_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          hs_fall, vs_fall, tick, timeout, fs_now;
    logic          line_err, frame_err, err_now, frame_clean;
    logic          h_act, v_act, vs_pend_cur;
    logic [DW-1:0] div_cur;

    // Registers; sync inputs reset to their idle-high level so reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            rgb_q         <= 3'b000;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vs_pend_q     <= 1'b0;
            skip_line_q   <= 1'b1;
            skip_frame_q  <= 1'b1;
            clean_q       <= 1'b0;
            clean_cnt_q   <= '0;
            state_q       <= ST_SEARCH;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= 3'b000;
            frame_start_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_pend_q     <= vs_pend_d;
            skip_line_q   <= skip_line_d;
            skip_frame_q  <= skip_frame_d;
            clean_q       <= clean_d;
            clean_cnt_q   <= clean_cnt_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            err_count_q   <= err_count_d;
        end
    end

    // Input stage, edge detect and pixel tick; hsync fall realigns the divider.
    always_comb begin
        hs_d      = hsync;
        vs_d      = vsync;
        rgb_d     = {red, green, blue};
        hs_prev_d = hs_q;
        vs_prev_d = vs_q;
        hs_fall   = hs_prev_q & ~hs_q;
        vs_fall   = vs_prev_q & ~vs_q;
        div_cur   = hs_fall ? '0 : div_q;
        tick      = (div_cur == '0);
        div_d     = (div_cur == DW'(CLK_DIV - 1)) ? '0 : div_cur + DW'(1);
    end

    // Horizontal/vertical counters and timing error detection.
    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        timeout      = 1'b0;
        vs_pend_cur  = vs_pend_q | vs_fall;
        fs_now       = hs_fall & vs_pend_cur;
        vs_pend_d    = fs_now ? 1'b0 : vs_pend_cur;
        skip_line_d  = skip_line_q;
        skip_frame_d = skip_frame_q;

        if (hs_fall) begin
            h_cnt_d = '0;
        end else if (tick && (h_cnt_q != HW'(H_MAX))) begin
            h_cnt_d = h_cnt_q + HW'(1);
            timeout = (h_cnt_d == HW'(H_MAX));
        end

        if (fs_now) begin
            v_cnt_d = '0;
        end else if (hs_fall && (v_cnt_q != '1)) begin
            v_cnt_d = v_cnt_q + VW'(1);
        end

        // A timed-out line has already been counted; its length is meaningless.
        line_err  = (hs_fall & ~skip_line_q & (h_cnt_q != HW'(H_TOTAL - 1))) | timeout;
        frame_err = fs_now & ~skip_frame_q & (v_cnt_q != VW'(V_TOTAL - 1));
        err_now   = line_err | frame_err;

        if (timeout) begin
            skip_line_d  = 1'b1;
            skip_frame_d = 1'b1;
        end else begin
            if (hs_fall) skip_line_d = 1'b0;
            if (fs_now)  skip_frame_d = 1'b0;
        end

        err_count_d = (err_now && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    // Lock FSM next state.
    always_comb begin
        state_d     = state_q;
        clean_cnt_d = clean_cnt_q;
        clean_d     = clean_q;
        frame_clean = clean_q & ~err_now;

        unique case (state_q)
            ST_SEARCH: begin
                clean_cnt_d = '0;
                if (fs_now) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (fs_now) begin
                    if (frame_clean) begin
                        clean_cnt_d = clean_cnt_q + CW'(1);
                        if (clean_cnt_d == CW'(LOCK_FRAMES)) state_d = ST_LOCKED;
                    end else begin
                        clean_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_now) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase

        // Each frame_start opens a fresh error-free window.
        if (fs_now) begin
            clean_d = 1'b1;
        end else if (err_now) begin
            clean_d = 1'b0;
        end
    end

    // Pixel capture and registered outputs.
    always_comb begin
        h_act         = (h_cnt_d >= HW'(H_START)) && (h_cnt_d <= HW'(H_END));
        v_act         = (v_cnt_d >= VW'(V_START)) && (v_cnt_d <= VW'(V_END));
        pix_valid_d   = tick & h_act & v_act & (state_q == ST_LOCKED);
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_rgb_d     = pix_rgb_q;
        if (pix_valid_d) begin
            pix_x_d   = 10'(h_cnt_d - HW'(H_START));
            pix_y_d   = 10'(v_cnt_d - VW'(V_START));
            pix_rgb_d = rgb_q;
        end
        locked_d      = (state_d == ST_LOCKED);
        frame_start_d = fs_now;
    end

    assign locked      = locked_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign err_count   = err_count_q;

endmodule
